// File: rtl/imem_line_fill.sv
// imem_line_fill: single 4-word instruction line buffer, refilled one word
// at a time over a req/gnt/rvalid memory port.
module imem_line_fill #(
    parameter int ADDR_LEN   = 32,
    parameter int INSN_LEN   = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_LEN-1:0]            pc,
    input  logic                           fetch_req,
    input  logic                           flush,
    input  logic                           invalidate,
    output logic [LINE_WORDS*INSN_LEN-1:0] idata,
    output logic                           idata_valid,
    output logic                           stall_if,
    output logic                           mem_req,
    output logic [ADDR_LEN-1:0]            mem_addr,
    input  logic                           mem_gnt,
    input  logic                           mem_rvalid,
    input  logic [INSN_LEN-1:0]            mem_rdata
);

    localparam int TAG_W = ADDR_LEN - 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [TAG_W-1:0]    fill_line_q, fill_line_d;
    logic                line_valid_q, line_valid_d;
    logic [1:0]          beat_q, beat_d;
    logic                abort_q, abort_d;
    logic                buf_we;
    logic                kill;
    logic [INSN_LEN-1:0] buf_q [LINE_WORDS];
    logic                unused_pc;

    assign unused_pc   = ^pc[3:0];
    assign kill        = flush | invalidate;
    assign idata_valid = line_valid_q && (tag_q == pc[ADDR_LEN-1:4]);
    assign stall_if    = fetch_req && !idata_valid;
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = {fill_line_q, beat_q, 2'b00};

    always_comb begin
        for (int k = 0; k < LINE_WORDS; k++) begin
            idata[k*INSN_LEN +: INSN_LEN] = buf_q[k];
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        fill_line_d  = fill_line_q;
        line_valid_d = line_valid_q;
        beat_d       = beat_q;
        abort_d      = abort_q;
        buf_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_req && !idata_valid && !kill) begin
                    fill_line_d  = pc[ADDR_LEN-1:4];
                    beat_d       = 2'd0;
                    line_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                // An issued request cannot be withdrawn; remember to drop it.
                if (kill) begin
                    abort_d = 1'b1;
                end
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (abort_q || kill) begin
                        abort_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        buf_we = 1'b1;
                        if (beat_q == 2'd3) begin
                            tag_d        = fill_line_q;
                            line_valid_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            beat_d  = beat_q + 2'd1;
                            state_d = REQ;
                        end
                    end
                end else if (kill) begin
                    abort_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // fence.i beats a line that completes in the same cycle.
        if (invalidate) begin
            line_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            fill_line_q  <= '0;
            line_valid_q <= 1'b0;
            beat_q       <= 2'd0;
            abort_q      <= 1'b0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            fill_line_q  <= fill_line_d;
            line_valid_q <= line_valid_d;
            beat_q       <= beat_d;
            abort_q      <= abort_d;
            if (buf_we) begin
                buf_q[beat_q] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_line_fill.sv
// tb_imem_line_fill: table-driven cold miss, directed corner cases and a
// randomized run against a memory model with random gnt/rvalid latency.
`timescale 1ns/1ps
module tb_imem_line_fill;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pc;
    logic         fetch_req;
    logic         flush;
    logic         invalidate;
    logic [127:0] idata;
    logic         idata_valid;
    logic         stall_if;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    int n_err = 0;
    int n_chk = 0;

    // memory responder knobs
    int          gnt_max = 0;
    int          rv_min = 1;
    int          rv_max = 1;
    logic [31:0] hold_addr = 32'hFFFF_FFFF;
    int          hold_cycles = 0;

    imem_line_fill dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .fetch_req  (fetch_req),
        .flush      (flush),
        .invalidate (invalidate),
        .idata      (idata),
        .idata_valid(idata_valid),
        .stall_if   (stall_if),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h10)
            return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    function automatic logic [127:0] line_data(input logic [27:0] l);
        logic [127:0] d;
        logic [1:0]   w;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            w = k[1:0];
            d[k*32 +: 32] = mem_word({l, w, 2'b00});
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] p, input logic fr,
                        input logic fl, input logic inv);
        @(negedge clk);
        pc = p;
        fetch_req = fr;
        flush = fl;
        invalidate = inv;
        #1;
    endtask

    // Hold the current inputs until the line becomes valid.
    task automatic wait_valid(input string name, input int limit,
                              output int cycles);
        cycles = -1;
        for (int k = 0; k < limit; k++) begin
            step(pc, fetch_req, 1'b0, 1'b0);
            if (idata_valid) begin
                cycles = k;
                break;
            end
        end
        if (cycles < 0)
            chk(name, 128'd0, 128'd1);
    endtask

    // Memory side: per-request gnt delay, rvalid a random delay after gnt.
    initial begin : responder
        int          rv_cnt;
        int          wait_cnt;
        int          cur_delay;
        logic        in_req;
        logic [31:0] rv_addr;
        rv_cnt = 0;
        wait_cnt = 0;
        cur_delay = 0;
        in_req = 1'b0;
        rv_addr = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom();
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mem_word(rv_addr);
                end
            end
            if (mem_req && rv_cnt == 0) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wait_cnt = 0;
                    cur_delay = (mem_addr == hold_addr) ? hold_cycles :
                                $urandom_range(0, gnt_max);
                end
                if (wait_cnt >= cur_delay) begin
                    mem_gnt = 1'b1;
                    rv_addr = mem_addr;
                    rv_cnt = $urandom_range(rv_min, rv_max);
                    in_req = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    // Always-on rules: stall formula, hit content, request stability,
    // beat ordering, no traffic while hitting.
    initial begin : monitor
        logic        prev_req;
        logic        prev_gnt;
        logic [31:0] prev_addr;
        logic [31:0] last_gnt;
        logic        ord_ok;
        prev_req = 1'b0;
        prev_gnt = 1'b0;
        prev_addr = '0;
        last_gnt = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                prev_req = 1'b0;
            end else begin
                chk("mon.stall", stall_if, fetch_req & ~idata_valid);
                if (idata_valid) begin
                    chk("mon.idata", idata, line_data(pc[31:4]));
                    chk("mon.hit_noreq", mem_req, 1'b0);
                end
                if (prev_req && !prev_gnt) begin
                    chk("mon.req_hold", mem_req, 1'b1);
                    chk("mon.addr_hold", mem_addr, prev_addr);
                end
                if (mem_req && mem_gnt) begin
                    ord_ok = (mem_addr[3:2] == 2'd0) ||
                             (mem_addr == last_gnt + 32'd4);
                    chk("mon.beat_order", ord_ok, 1'b1);
                    last_gnt = mem_addr;
                end
                prev_req = mem_req;
                prev_gnt = mem_gnt;
                prev_addr = mem_addr;
            end
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic        fr;
        logic        req;
        logic [31:0] addr;
        logic        stall;
        logic        vld;
        logic        dchk;
    } vec_t;

    vec_t tbl[12];

    initial begin : main
        int          lat;
        int          n304;
        int          bad;
        int          first_k;
        logic [31:0] first_addr;
        logic        found;
        int          stall_run;
        int          fills;
        logic        prev_v;
        logic [31:0] lines[5];
        logic [31:0] cur_line;
        logic        fl;
        logic        inv;

        // cold miss on 0x100, zero-wait memory, then hits
        tbl[0]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{32'h100, 1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{32'h100, 1'b1, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{32'h100, 1'b1, 1'b1, 32'h10C, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{32'h10C, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{32'h108, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1};

        reset = 1'b0;
        pc = 32'h100;
        fetch_req = 1'b1;
        flush = 1'b0;
        invalidate = 1'b0;
        #1;
        chk("rst.idata", idata, 128'd0);
        chk("rst.valid", idata_valid, 1'b0);
        chk("rst.req", mem_req, 1'b0);
        chk("rst.addr", mem_addr, 32'd0);
        chk("rst.stall", stall_if, 1'b1);
        repeat (2) @(negedge clk);
        fetch_req = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].pc, tbl[i].fr, 1'b0, 1'b0);
            chk($sformatf("cold[%0d].req", i), mem_req, tbl[i].req);
            if (tbl[i].req)
                chk($sformatf("cold[%0d].addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("cold[%0d].stall", i), stall_if, tbl[i].stall);
            chk($sformatf("cold[%0d].valid", i), idata_valid, tbl[i].vld);
            if (tbl[i].dchk)
                chk($sformatf("cold[%0d].idata", i), idata,
                    128'h00000044_00000033_00000022_00000011);
        end

        // beat 1 gnt held low for 3 cycles
        hold_addr = 32'h304;
        hold_cycles = 3;
        lat = -1;
        n304 = 0;
        for (int k = 0; k < 40; k++) begin
            step(32'h300, 1'b1, 1'b0, 1'b0);
            if (mem_req && mem_addr == 32'h304)
                n304++;
            if (idata_valid) begin
                lat = k;
                break;
            end
        end
        chk("bp.latency", lat, 12);
        chk("bp.req_cycles", n304, 4);
        chk("bp.idata", idata, line_data(28'h30));
        hold_cycles = 0;
        hold_addr = 32'hFFFF_FFFF;

        // flush while waiting on beat 2, redirect to 0x200
        rv_min = 2;
        rv_max = 2;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(32'h400, 1'b1, 1'b0, 1'b0);
            if (mem_req && mem_gnt && mem_addr == 32'h408) begin
                found = 1'b1;
                break;
            end
        end
        chk("fl.reach_beat2", found, 1'b1);
        step(32'h200, 1'b1, 1'b1, 1'b0);
        step(32'h200, 1'b1, 1'b0, 1'b0);
        chk("fl.discard_valid", idata_valid, 1'b0);
        bad = 0;
        first_k = -1;
        first_addr = '0;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step(32'h200, 1'b1, 1'b0, 1'b0);
            if (mem_req && mem_addr[31:4] == 28'h40)
                bad++;
            if (mem_req && first_k < 0) begin
                first_k = k;
                first_addr = mem_addr;
            end
            if (idata_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("fl.old_line_reqs", bad, 0);
        chk("fl.new_first_k", first_k, 1);
        chk("fl.new_first_addr", first_addr, 32'h200);
        chk("fl.new_done", found, 1'b1);
        chk("fl.new_idata", idata, line_data(28'h20));
        step(32'h400, 1'b1, 1'b0, 1'b0);
        chk("fl.old_tag_valid", idata_valid, 1'b0);
        rv_min = 1;
        rv_max = 1;

        // invalidate together with the final rvalid
        found = 1'b0;
        for (int k = 0; k < 80; k++) begin
            step(32'h500, 1'b1, 1'b0, 1'b0);
            if (mem_req && mem_gnt && mem_addr == 32'h50C) begin
                found = 1'b1;
                break;
            end
        end
        chk("inv.reach_beat3", found, 1'b1);
        step(32'h500, 1'b1, 1'b0, 1'b1);
        step(32'h500, 1'b1, 1'b0, 1'b0);
        chk("inv.valid", idata_valid, 1'b0);
        chk("inv.stall", stall_if, 1'b1);
        chk("inv.idle_req", mem_req, 1'b0);
        step(32'h500, 1'b1, 1'b0, 1'b0);
        chk("inv.refill_req", mem_req, 1'b1);
        chk("inv.refill_addr", mem_addr, 32'h500);
        wait_valid("inv.refill_timeout", 40, lat);
        chk("inv.refill_idata", idata, line_data(28'h50));

        // asynchronous reset while requesting beat 1
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(32'h600, 1'b1, 1'b0, 1'b0);
            if (mem_req && mem_addr == 32'h604) begin
                found = 1'b1;
                break;
            end
        end
        chk("ar.reach_req", found, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("ar.req", mem_req, 1'b0);
        chk("ar.idata", idata, 128'd0);
        chk("ar.valid", idata_valid, 1'b0);
        chk("ar.addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        first_k = -1;
        first_addr = '0;
        for (int k = 0; k < 10; k++) begin
            step(32'h600, 1'b1, 1'b0, 1'b0);
            if (mem_req) begin
                first_k = k;
                first_addr = mem_addr;
                break;
            end
        end
        chk("ar.restart_k", first_k, 0);
        chk("ar.restart_addr", first_addr, 32'h600);
        wait_valid("ar.refill_timeout", 40, lat);
        chk("ar.refill_idata", idata, line_data(28'h60));

        // randomized traffic; monitor checks every cycle
        gnt_max = 3;
        rv_min = 1;
        rv_max = 2;
        lines[0] = 32'h0000_0100;
        lines[1] = 32'h0000_0200;
        lines[2] = 32'h0000_0700;
        lines[3] = 32'h0000_0800;
        lines[4] = 32'h1000_0040;
        cur_line = lines[0];
        stall_run = 0;
        fills = 0;
        prev_v = idata_valid;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0)
                cur_line = lines[$urandom_range(0, 4)];
            fl = ($urandom_range(0, 49) == 0);
            inv = ($urandom_range(0, 49) == 0);
            step(cur_line | ($urandom_range(0, 3) << 2),
                 ($urandom_range(0, 9) != 0), fl, inv);
            if (!fetch_req || fl || inv || !stall_if)
                stall_run = 0;
            else
                stall_run++;
            if (stall_run > 100) begin
                chk("rand.liveness", stall_run, 0);
                stall_run = 0;
            end
            if (idata_valid && !prev_v)
                fills++;
            prev_v = idata_valid;
        end
        chk("rand.progress", (fills > 20), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_line_fill.md
Name: imem_line_fill

Overview:
- Instruction-side line server that produces the 128-bit `idata` line consumed by the fetch stage.
- Holds one 4-word line buffer tagged by `pc[31:4]`.
- On a miss, fills the line from a 32-bit word-wide instruction memory port using a req/gnt/rvalid handshake, one beat at a time.
- Asserts `stall_if` until the line is present; supports pipeline flush (abort fill) and fence.i invalidate.

Parameters:
- ADDR_LEN, 32, PC/memory address width.
- INSN_LEN, 32, instruction and memory beat width.
- LINE_WORDS, 4, words per line; fixed at 4; `idata` width = LINE_WORDS*INSN_LEN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pc  in  ADDR_LEN  fetch PC; line index = `pc[31:4]`.
- fetch_req  in  1  fetch stage needs the line for `pc` this cycle.
- flush  in  1  mispredict/redirect: abandon in-flight fill.
- invalidate  in  1  fence.i: drop buffered line and any in-flight fill.
- idata  out  4*INSN_LEN  line buffer; word k at bits [32k+31:32k] = mem[{tag,k,2'b00}].
- idata_valid  out  1  line_valid & (tag == pc[31:4]); combinational.
- stall_if  out  1  fetch_req & ~idata_valid.
- mem_req  out  1  beat read request.
- mem_addr  out  ADDR_LEN  {fill_line, beat, 2'b00}.
- mem_gnt  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  read data valid; at most one per accepted request, earliest the cycle after gnt.
- mem_rdata  in  INSN_LEN  read data.

Behaviour:
- Reset (reset==0, async): state=IDLE, line_valid=0, tag=0, buffer=0, beat=0, abort=0, mem_req=0. Consequently idata=0, idata_valid=0, mem_addr=0.
- State machine: IDLE, REQ, WAIT.
- IDLE:
  - If fetch_req & ~idata_valid & ~flush & ~invalidate: latch fill_line=pc[31:4], beat=0, clear line_valid, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req=1, mem_addr={fill_line,beat,2'b00}.
  - mem_req and mem_addr are held stable until mem_gnt.
  - On mem_gnt go to WAIT.
  - flush or invalidate in REQ sets abort but does not drop mem_req: the request must complete.
- WAIT:
  - mem_req=0.
  - On mem_rvalid:
    - If abort: discard data, clear abort, go to IDLE.
    - Else write mem_rdata into buffer word[beat].
    - If beat==3: tag=fill_line, line_valid=1, go to IDLE.
    - Else beat+1, go to REQ.
  - flush or invalidate in WAIT without rvalid sets abort.
  - flush or invalidate with rvalid in the same cycle: the data is discarded (abort wins).
- mem_rvalid outside WAIT is ignored.
- invalidate in any state clears line_valid next edge. invalidate in the same cycle as final-beat completion leaves line_valid=0.
- flush does not clear a valid buffered line; only in-flight fills are abandoned.
- After an abort returns to IDLE, a new miss is detected from the current pc the following cycle.
- pc may change during a fill. The fill continues for the latched fill_line, and idata_valid stays 0 unless pc matches a valid tag. The new line misses after completion.
- Latency (zero-wait gnt, rvalid 1 cycle after gnt):
  - Miss seen in IDLE at cycle t.
  - mem_req at t+1, t+3, t+5, t+7.
  - Final rvalid at t+8.
  - idata_valid=1, stall_if=0 at t+9.
- Hit: idata_valid same cycle, zero latency, no memory traffic.
- beat is 2 bits and never wraps past 3 within a fill.

Test Plan:
- Cold miss: reset release, pc=0x00000100, fetch_req=1, mem gnt immediate, rvalid +1 cycle returning 0x11,0x22,0x33,0x44 -> mem_addr 0x100,0x104,0x108,0x10C in order; idata=0x00000044_00000033_00000022_00000011 and idata_valid=1 exactly 9 cycles after the miss; stall_if high before.
- Hit: pc moves to 0x10C with the line valid -> idata_valid=1 the same cycle, mem_req stays 0.
- Gnt backpressure: gnt held low 3 cycles on beat 1 -> mem_req and mem_addr=0x104 stable throughout; completion delayed by exactly 3 cycles.
- Flush mid-fill: flush pulsed in WAIT of beat 2 -> beat-2 rvalid is discarded, no further mem_req for the old line; new pc=0x200 miss starts a fill at 0x200; the old tag is never marked valid.
- Invalidate on completion: invalidate asserted the same cycle as the beat-3 rvalid -> idata_valid=0 afterwards; with fetch_req still high, a refill of the same line begins.
- Async reset mid-fill: reset low in REQ -> mem_req=0, idata=0, idata_valid=0 immediately without a clock edge; after release, the fill restarts from beat 0.
